// File: rtl/vend_session_ctrl_pkg.sv
// Shared definitions for the vending-machine session sequencer.
//   state_t        : FSM state codes (also decoded for the debug LEDs)
//   DEF_*          : default timeouts in seconds
//   load_value()   : clamps a timeout to the 4-bit counter range 1..15
//   shows_count()  : states in which the countdown is presented
package vend_session_ctrl_pkg;

  localparam int COIN_W            = 3;
  localparam int CNT_W             = 4;
  localparam int DEF_IDLE_TIMEOUT  = 9;
  localparam int DEF_DISPENSE_HOLD = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVE   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_FINISH   = 3'd3,
    ST_CANCEL   = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  // Out-of-range timeouts are pinned to the nearest legal value so the
  // counter load can never truncate to something surprising.
  function automatic cnt_t load_value(input int seconds);
    if (seconds < 1)  return cnt_t'(1);
    if (seconds > 15) return cnt_t'(15);
    return cnt_t'(seconds);
  endfunction

  function automatic logic shows_count(input state_t s);
    return (s == ST_ACTIVE) || (s == ST_DISPENSE);
  endfunction

endpackage

// File: rtl/vend_session_ctrl_sync2.sv
// Two-flop synchronizer for one asynchronous level into the clk_1 domain.
//   clk_1  : 1 Hz tick clock
//   reset  : asynchronous, active-high; clears both flops
//   d      : asynchronous level
//   q      : synchronized level, two clk_1 edges after d
module vend_session_ctrl_sync2 (
  input  logic clk_1,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vend_session_ctrl.sv
// Session sequencer for the vending machine, clocked by the 1 Hz tick clk_1.
// Auto-cancels an idle purchase after IDLE_TIMEOUT seconds and auto-finishes
// a dispense after DISPENSE_HOLD seconds.
//
// Ports
//   clk_1          in   1  1 Hz tick clock
//   reset          in   1  asynchronous, active-high
//   i_coin         in   3  coin switch levels (async)
//   i_confirm      in   1  confirm switch level (async)
//   i_cancel       in   1  manual cancel switch level (async)
//   i_ready        in   1  machine ready flag (other clock domain)
//   i_goods        in   1  goods-dispensed flag (other clock domain)
//   o_auto_cancel  out  1  one-cycle cancel request
//   o_auto_finish  out  1  one-cycle finish request
//   o_countdown    out  4  seconds remaining in ACTIVE/DISPENSE, else 0
//   o_state        out  3  current state code
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no session; waits for activity or goods
// ACTIVE   | purchase in progress; idle timer running
// DISPENSE | goods presented; hold timer running
// FINISH   | one-cycle auto-finish pulse
// CANCEL   | one-cycle auto-cancel pulse
// RELEASE  | waits for machine ready with goods taken
module vend_session_ctrl
  import vend_session_ctrl_pkg::*;
#(
  parameter int IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT,
  parameter int DISPENSE_HOLD = DEF_DISPENSE_HOLD
) (
  input  logic              clk_1,
  input  logic              reset,
  input  logic [COIN_W-1:0] i_coin,
  input  logic              i_confirm,
  input  logic              i_cancel,
  input  logic              i_ready,
  input  logic              i_goods,
  output logic              o_auto_cancel,
  output logic              o_auto_finish,
  output logic [CNT_W-1:0]  o_countdown,
  output logic [2:0]        o_state
);

  localparam cnt_t IDLE_LOAD = load_value(IDLE_TIMEOUT);
  localparam cnt_t HOLD_LOAD = load_value(DISPENSE_HOLD);

  logic [COIN_W-1:0] coin_s;
  logic [COIN_W-1:0] coin_prev;
  logic              confirm_s;
  logic              confirm_prev;
  logic              cancel_s;
  logic              ready_s;
  logic              goods_s;
  logic              activity;

  state_t state;
  state_t state_next;
  cnt_t   cnt;
  cnt_t   cnt_next;

  for (genvar b = 0; b < COIN_W; b++) begin : g_coin_sync
    vend_session_ctrl_sync2 u_sync (
      .clk_1 (clk_1),
      .reset (reset),
      .d     (i_coin[b]),
      .q     (coin_s[b])
    );
  end

  vend_session_ctrl_sync2 u_sync_confirm (
    .clk_1 (clk_1),
    .reset (reset),
    .d     (i_confirm),
    .q     (confirm_s)
  );

  vend_session_ctrl_sync2 u_sync_cancel (
    .clk_1 (clk_1),
    .reset (reset),
    .d     (i_cancel),
    .q     (cancel_s)
  );

  vend_session_ctrl_sync2 u_sync_ready (
    .clk_1 (clk_1),
    .reset (reset),
    .d     (i_ready),
    .q     (ready_s)
  );

  vend_session_ctrl_sync2 u_sync_goods (
    .clk_1 (clk_1),
    .reset (reset),
    .d     (i_goods),
    .q     (goods_s)
  );

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      coin_prev    <= '0;
      confirm_prev <= 1'b0;
    end else begin
      coin_prev    <= coin_s;
      confirm_prev <= confirm_s;
    end
  end

  // Any coin movement counts; confirm only on its rising edge.
  assign activity = (coin_s != coin_prev) | (confirm_s & ~confirm_prev);

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Branch order inside each state encodes the priority
  // goods > cancel > activity > expiry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (goods_s) begin
          state_next = ST_DISPENSE;
          cnt_next   = HOLD_LOAD;
        end else if (activity) begin
          state_next = ST_ACTIVE;
          cnt_next   = IDLE_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (goods_s) begin
          state_next = ST_DISPENSE;
          cnt_next   = HOLD_LOAD;
        end else if (cancel_s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (activity) begin
          cnt_next   = IDLE_LOAD;
        end else if (cnt == '0) begin
          state_next = ST_CANCEL;
        end else begin
          cnt_next   = cnt - cnt_t'(1);
        end
      end
      ST_DISPENSE: begin
        if (!goods_s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          state_next = ST_FINISH;
        end else begin
          cnt_next   = cnt - cnt_t'(1);
        end
      end
      ST_FINISH, ST_CANCEL: begin
        state_next = ST_RELEASE;
        cnt_next   = '0;
      end
      ST_RELEASE: begin
        cnt_next = '0;
        if (ready_s && !goods_s) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are loaded from the next-state values so they change on the
  // same edge as the state register.
  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      o_state       <= 3'd0;
      o_countdown   <= '0;
      o_auto_cancel <= 1'b0;
      o_auto_finish <= 1'b0;
    end else begin
      o_state       <= state_next;
      o_countdown   <= shows_count(state_next) ? cnt_next : '0;
      o_auto_cancel <= (state_next == ST_CANCEL);
      o_auto_finish <= (state_next == ST_FINISH);
    end
  end

endmodule
